// File: rtl/inputc_nvc_if.sv
// inputc_nvc_if -- flit/switch bundle between a router input port and its
// neighbours.
//   idata/ivalid/ivch : incoming flit, write strobe, target VC
//   ordy/oack/olck    : per-VC not-full, credit-return pulse, mid-packet lock
//   req/port/grt      : switch request, requested output port, grant
//   odata/ovalid/ovch : registered outgoing flit, valid, source VC
//   err               : sticky protocol-error flag
// master = upstream/switch side (test or router core), slave = input unit.
interface inputc_nvc_if #(
  parameter int DATAW  = 32,
  parameter int NUM_VC = 4
);
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  logic [DATAW-1:0]  idata;
  logic              ivalid;
  logic [VW-1:0]     ivch;
  logic [NUM_VC-1:0] ordy;
  logic [NUM_VC-1:0] oack;
  logic [NUM_VC-1:0] olck;
  logic              req;
  logic [2:0]        port;
  logic              grt;
  logic [DATAW-1:0]  odata;
  logic              ovalid;
  logic [VW-1:0]     ovch;
  logic              err;

  modport master (
    output idata, ivalid, ivch, grt,
    input  ordy, oack, olck, req, port, odata, ovalid, ovch, err
  );

  modport slave (
    input  idata, ivalid, ivch, grt,
    output ordy, oack, olck, req, port, odata, ovalid, ovch, err
  );
endinterface

// File: rtl/inputc_nvc.sv
// inputc_nvc -- wormhole router input unit with NUM_VC virtual channels.
// Each VC has a DEPTH-entry FIFO, an IDLE/ACTIVE packet FSM and an XY route
// latch (inputc_nvc_vc). The top picks one eligible VC round-robin, raises
// req/port, and on grant dequeues the flit into a registered output stage.
// Ports: clk, rst_ (sync, active low), bus (inputc_nvc_if.slave).

// Per-VC lane: FIFO, packet FSM, route computation, eligibility/flush.
//   wr_i/wdata_i : enqueue (caller has already checked not-full)
//   gnt_i        : switch-granted dequeue of this VC
//   full_o, lck_o, elig_o, flush_o, port_o, head_o : lane status / head flit
module inputc_nvc_vc #(
  parameter int DATAW   = 32,
  parameter int DEPTH   = 4,
  parameter int CW      = 2,
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             wr_i,
  input  logic [DATAW-1:0] wdata_i,
  input  logic             gnt_i,
  output logic             full_o,
  output logic             lck_o,
  output logic             elig_o,
  output logic             flush_o,
  output logic [2:0]       port_o,
  output logic [DATAW-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] MYX = CW'(MY_XPOS);
  localparam logic [CW-1:0] MYY = CW'(MY_YPOS);
  localparam logic [1:0] T_HEAD = 2'b00, T_TAIL = 2'b10;
  localparam logic [2:0] P_N = 3'd0, P_E = 3'd1, P_S = 3'd2, P_W = 3'd3, P_L = 3'd4;

  typedef enum logic {IDLE, ACTIVE} st_t;

  st_t              st_q;
  logic [DATAW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic [2:0]       port_q;
  logic [2:0]       route;
  logic [1:0]       typ;
  logic             is_head, empty, deq;
  logic [CW-1:0]    dstx, dsty;

  assign head_o  = mem_q[rd_q];
  assign typ     = head_o[DATAW-1:DATAW-2];
  // HEAD (00) and HEADTAIL (11) are the two packet-opening types
  assign is_head = (typ[1] == typ[0]);
  assign empty   = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign lck_o   = (st_q == ACTIVE);
  assign elig_o  = !empty && (is_head ? (st_q == IDLE) : (st_q == ACTIVE));
  // a head flit that cannot legally be forwarded is discarded in place
  assign flush_o = !empty && !elig_o;
  assign deq     = gnt_i || flush_o;
  assign dstx    = head_o[2*CW-1:CW];
  assign dsty    = head_o[CW-1:0];

  always_comb begin
    route = P_L;
    if      (dstx > MYX) route = P_E;
    else if (dstx < MYX) route = P_W;
    else if (dsty > MYY) route = P_S;
    else if (dsty < MYY) route = P_N;
  end

  // body/tail flits carry no destination; they follow the latched route
  assign port_o = is_head ? route : port_q;

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      port_q <= P_L;
      st_q   <= IDLE;
    end else begin
      if (wr_i) wr_q <= wr_q + 1'b1;
      if (deq)  rd_q <= rd_q + 1'b1;
      case ({wr_i, deq})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      // flushes leave the FSM alone; only granted dequeues move it
      if (gnt_i) begin
        if (is_head) begin
          port_q <= route;
          if (typ == T_HEAD) st_q <= ACTIVE;
        end else if (typ == T_TAIL) begin
          st_q <= IDLE;
        end
      end
    end
  end
endmodule

module inputc_nvc #(
  parameter int DATAW   = 32,
  parameter int NUM_VC  = 4,
  parameter int DEPTH   = 4,
  parameter int CW      = 2,
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0
) (
  input  logic         clk,
  input  logic         rst_,
  inputc_nvc_if.slave  bus
);
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  logic [NUM_VC-1:0]            full, lck, elig, flush, wr_v, gnt_v;
  logic [NUM_VC-1:0][2:0]       vport;
  logic [NUM_VC-1:0][DATAW-1:0] vhead;

  logic [VW-1:0]    rr_q, sel_q, pick;
  logic             hold_q, req, gnt;
  logic [DATAW-1:0] odata_q;
  logic             ovalid_q, err_q;
  logic [VW-1:0]    ovch_q;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr_v[v]  = bus.ivalid && (bus.ivch == VW'(v)) && !full[v];
    assign gnt_v[v] = gnt && (pick == VW'(v));

    inputc_nvc_vc #(
      .DATAW(DATAW), .DEPTH(DEPTH), .CW(CW),
      .MY_XPOS(MY_XPOS), .MY_YPOS(MY_YPOS)
    ) u_vc (
      .clk     (clk),
      .rst_    (rst_),
      .wr_i    (wr_v[v]),
      .wdata_i (bus.idata),
      .gnt_i   (gnt_v[v]),
      .full_o  (full[v]),
      .lck_o   (lck[v]),
      .elig_o  (elig[v]),
      .flush_o (flush[v]),
      .port_o  (vport[v]),
      .head_o  (vhead[v])
    );
  end

  // Round-robin from rr_q; an ungranted request keeps its VC so req/port
  // stay stable until the switch answers.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = sel_q;
    if (!hold_q) begin
      for (int i = 0; i < NUM_VC; i++) begin
        idx = int'(rr_q) + i;
        if (idx >= NUM_VC) idx = idx - NUM_VC;
        if (!found && elig[idx]) begin
          found = 1'b1;
          pick  = VW'(idx);
        end
      end
    end
  end

  assign req = rst_ && (|elig);
  assign gnt = req && bus.grt;

  assign bus.req    = req;
  assign bus.port   = req ? vport[pick] : 3'd0;
  assign bus.oack   = rst_ ? (gnt_v | flush) : '0;
  assign bus.olck   = rst_ ? lck : '0;
  assign bus.ordy   = ~full;
  assign bus.odata  = odata_q;
  assign bus.ovalid = ovalid_q;
  assign bus.ovch   = ovch_q;
  assign bus.err    = err_q;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      rr_q     <= '0;
      sel_q    <= '0;
      hold_q   <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      sel_q    <= pick;
      hold_q   <= req && !bus.grt;
      ovalid_q <= gnt;
      odata_q  <= gnt ? vhead[pick] : '0;
      ovch_q   <= gnt ? pick : '0;
      if (gnt) rr_q <= (pick == VW'(NUM_VC-1)) ? '0 : pick + 1'b1;
      // a strobe no VC accepted is either full or addressed out of range
      if ((bus.ivalid && !(|wr_v)) || (|flush)) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_inputc_nvc.sv
module tb_inputc_nvc;
  localparam int DATAW = 32, NUM_VC = 4;
  localparam logic [1:0] HD = 2'b00, BD = 2'b01, TL = 2'b10, HT = 2'b11;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  vc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_;
  int   n_vec = 0, n_mis = 0;
  exp_t sb[$];

  inputc_nvc_if #(.DATAW(DATAW), .NUM_VC(NUM_VC)) bus ();

  // router placed at (1,1) so every route direction is reachable
  inputc_nvc #(.DATAW(DATAW), .NUM_VC(NUM_VC), .DEPTH(4), .CW(2),
               .MY_XPOS(1), .MY_YPOS(1)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(logic [1:0] t, logic [1:0] x, logic [1:0] y,
                                     logic [25:0] tag);
    return {t, tag, x, y};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(logic [31:0] d, logic [1:0] vc);
    exp_t e;
    e.d = d; e.vc = vc;
    sb.push_back(e);
  endtask

  // called at posedge+1; returns at the following posedge+1
  task automatic wr1(logic [1:0] vc, logic [31:0] f);
    bus.ivalid = 1'b1; bus.ivch = vc; bus.idata = f;
    @(posedge clk); #1;
    bus.ivalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    @(posedge clk); #1;
    rst_ = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // output monitor: every ovalid must match the next expected flit
  always @(negedge clk) begin
    if (rst_ === 1'b1) begin
      if (bus.ovalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_ovalid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("odata", bus.odata, e.d);
          chk("ovch", bus.ovch, e.vc);
        end
      end else begin
        chk("odata_idle_zero", bus.odata, 0);
      end
    end
  end

  initial begin
    logic [31:0] f [4];
    logic [2:0]  pexp [4];
    rst_ = 1'b0; bus.ivalid = 1'b0; bus.ivch = '0; bus.idata = '0; bus.grt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ordy", bus.ordy, 4'hF);
    chk("rst_oack", bus.oack, 0);
    chk("rst_req", bus.req, 0);
    chk("rst_olck", bus.olck, 0);
    chk("rst_ovalid", bus.ovalid, 0);
    chk("rst_odata", bus.odata, 0);
    chk("rst_err", bus.err, 0);
    step(); rst_ = 1'b1;

    // single HEADTAIL, grant tied high: dst (2,1) -> East
    bus.grt = 1'b1;
    f[0] = mk(HT, 2'd2, 2'd1, 26'h0A0);
    push(f[0], 0);
    wr1(0, f[0]);
    @(negedge clk);
    chk("ht_req", bus.req, 1);
    chk("ht_port", bus.port, 1);
    chk("ht_oack", bus.oack, 4'b0001);
    chk("ht_olck", bus.olck, 0);
    step();
    @(negedge clk);
    chk("ht_ovalid", bus.ovalid, 1);
    chk("ht_olck2", bus.olck, 0);
    chk("ht_req_after", bus.req, 0);
    step();

    // 3-flit packet to VC2, dst (1,1) -> Local, buffered then granted
    bus.grt = 1'b0;
    f[0] = mk(HD, 2'd1, 2'd1, 26'h1);
    f[1] = mk(BD, 2'd3, 2'd0, 26'h2);  // body payload bits must not steer
    f[2] = mk(TL, 2'd0, 2'd3, 26'h3);
    for (int i = 0; i < 3; i++) begin
      push(f[i], 2);
      wr1(2, f[i]);
    end
    @(negedge clk);
    chk("pkt_wait_oack", bus.oack, 0);
    chk("pkt_wait_port", bus.port, 4);
    step();
    bus.grt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pkt_req", bus.req, 1);
      chk("pkt_port", bus.port, 4);
      chk("pkt_oack", bus.oack, 4'b0100);
      chk("pkt_olck", bus.olck, (i == 0) ? 4'b0000 : 4'b0100);
      step();
    end
    @(negedge clk);
    chk("pkt_olck_end", bus.olck, 0);
    chk("pkt_req_end", bus.req, 0);
    step();

    // round-robin: all VCs hold a HEADTAIL, grant held low 3 cycles first
    do_reset();
    bus.grt = 1'b0;
    f[0] = mk(HT, 2'd0, 2'd1, 26'h10); pexp[0] = 3;  // West
    f[1] = mk(HT, 2'd1, 2'd0, 26'h11); pexp[1] = 0;  // North
    f[2] = mk(HT, 2'd1, 2'd2, 26'h12); pexp[2] = 2;  // South
    f[3] = mk(HT, 2'd2, 2'd2, 26'h13); pexp[3] = 1;  // East
    for (int i = 0; i < 4; i++) begin
      push(f[i], 2'(i));
      wr1(2'(i), f[i]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_hold_req", bus.req, 1);
      chk("rr_hold_port", bus.port, 3);
      chk("rr_hold_oack", bus.oack, 0);
      step();
    end
    bus.grt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_oack", bus.oack, 4'b0001 << i);
      chk("rr_port", bus.port, pexp[i]);
      step();
    end
    bus.grt = 1'b0;
    @(negedge clk);
    chk("rr_req_end", bus.req, 0);
    step();

    // overflow: DEPTH+1 writes to VC1 with no grant
    for (int i = 0; i < 5; i++) begin
      f[0] = mk(HT, 2'd1, 2'd1, 26'(32'h20 + i));
      if (i < 4) push(f[0], 1);
      wr1(1, f[0]);
      @(negedge clk);
      chk("ovf_ordy1", bus.ordy[1], (i < 3) ? 1 : 0);
      chk("ovf_err", bus.err, (i == 4) ? 1 : 0);
      step();
    end
    bus.grt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ovf_drain_oack", bus.oack, 4'b0010);
      step();
    end
    @(negedge clk);
    chk("ovf_drained_req", bus.req, 0);
    chk("ovf_drained_oack", bus.oack, 0);
    chk("ovf_ordy", bus.ordy, 4'hF);
    step();

    // BODY into IDLE VC3 is flushed (grant high but must be ignored)
    do_reset();
    bus.grt = 1'b1;
    wr1(3, mk(BD, 2'd2, 2'd2, 26'h30));
    @(negedge clk);
    chk("fl_req", bus.req, 0);
    chk("fl_oack", bus.oack, 4'b1000);
    chk("fl_err_pre", bus.err, 0);
    step();
    @(negedge clk);
    chk("fl_oack_after", bus.oack, 0);
    chk("fl_err", bus.err, 1);
    chk("fl_ovalid", bus.ovalid, 0);
    chk("fl_ordy", bus.ordy, 4'hF);
    step();

    // reset mid-packet on VC1
    do_reset();
    bus.grt = 1'b1;
    f[0] = mk(HD, 2'd2, 2'd1, 26'h40);
    push(f[0], 1);
    wr1(1, f[0]);
    @(negedge clk);
    chk("mr_port", bus.port, 1);
    step();
    bus.grt = 1'b0;
    @(negedge clk);
    chk("mr_olck", bus.olck, 4'b0010);
    step();
    wr1(1, mk(BD, 2'd0, 2'd0, 26'h41));
    rst_ = 1'b0;
    @(negedge clk);
    chk("mr_in_rst_olck", bus.olck, 0);
    chk("mr_in_rst_oack", bus.oack, 0);
    chk("mr_in_rst_req", bus.req, 0);
    step();
    rst_ = 1'b1;
    @(negedge clk);
    chk("mr_olck_after", bus.olck, 0);
    chk("mr_ordy_after", bus.ordy, 4'hF);
    chk("mr_ovalid_after", bus.ovalid, 0);
    chk("mr_oack_after", bus.oack, 0);
    chk("mr_err_after", bus.err, 0);
    step();
    bus.grt = 1'b1;
    f[0] = mk(HD, 2'd0, 2'd1, 26'h42);
    push(f[0], 1);
    wr1(1, f[0]);
    @(negedge clk);
    chk("mr_new_req", bus.req, 1);
    chk("mr_new_port", bus.port, 3);
    chk("mr_new_oack", bus.oack, 4'b0010);
    step();
    bus.grt = 1'b0;
    @(negedge clk);
    chk("mr_new_olck", bus.olck, 4'b0010);
    step();

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
